// File: rtl/sdl_pkg.sv
// Shared definitions for the SDL bus receiver and transmitter.
// Optional parity build is selected with SDL_RX_PARITY_EN.
package sdl_pkg;

  localparam int SDL_CLK_DIV_MIN = 4;

  typedef enum logic [2:0] {
    SDL_IDLE,
    SDL_START,
    SDL_DATA,
    SDL_PARITY,
    SDL_STOP,
    SDL_ACK
  } sdl_state_e;

  // Even parity holds when the data bits and the parity bit XOR to zero.
  function automatic logic sdl_even_ok(input logic [15:0] bits, input logic par);
    return ~(^bits ^ par);
  endfunction

endpackage

// File: rtl/sdl_sync_edge.sv
// 2-FF synchroniser for the SDL line plus a falling-edge detector on the synchronised value.
// The flops reset to 1 so the idle (pulled-up) line never produces a spurious edge.
module sdl_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = din;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign sync_o = s2_q;
  assign fall_o = s3_q & ~s2_q;

endmodule

// File: rtl/sdl_rx.sv
// SDL bus receiver: deserialises start/data/[parity]/stop frames and ACKs by pulling the line low.
// Define SDL_RX_PARITY_EN to expect one even-parity bit after the data bits.
module sdl_rx
  import sdl_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire               sdl,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int TMR_W = $clog2(CLK_DIV);
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(CLK_DIV / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  sdl_state_e        state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              ack_oe_q, ack_oe_d;
`ifdef SDL_RX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic s2, fall, bit_end, par_ok;

  sdl_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (sdl),
    .sync_o (s2),
    .fall_o (fall)
  );

  assign bit_end = (timer_q == TMR_LAST);

  always_comb begin
    state_d     = state_q;
    timer_d     = bit_end ? '0 : timer_q + 1'b1;
    idx_d       = idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    ack_oe_d    = ack_oe_q;
    par_ok      = 1'b1;
`ifdef SDL_RX_PARITY_EN
    parity_d    = parity_q;
    par_ok      = sdl_even_ok(16'(shift_q), parity_q);
`endif

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    unique case (state_q)
      SDL_IDLE: begin
        timer_d = '0;
        idx_d   = '0;
        if (fall) state_d = SDL_START;
      end
      // Re-centre the timer on the middle of the start bit; a high line here was a glitch.
      SDL_START: begin
        if (timer_q == TMR_HALF) begin
          timer_d = '0;
          state_d = s2 ? SDL_IDLE : SDL_DATA;
        end
      end
      SDL_DATA: begin
        if (bit_end) begin
          shift_d             = shift_q >> 1;
          shift_d[DATA_W-1]   = s2;
          idx_d               = idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
`ifdef SDL_RX_PARITY_EN
            state_d = SDL_PARITY;
`else
            state_d = SDL_STOP;
`endif
          end
        end
      end
      SDL_PARITY: begin
        if (bit_end) begin
`ifdef SDL_RX_PARITY_EN
          parity_d = s2;
`endif
          state_d = SDL_STOP;
        end
      end
      // A consumer accepting in this very cycle frees the holding register for the new word.
      SDL_STOP: begin
        if (bit_end) begin
          if (!s2 || !par_ok) begin
            frame_err_d = 1'b1;
            state_d     = SDL_IDLE;
          end else if (!rx_valid_q || rx_ready) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            ack_oe_d   = 1'b1;
            state_d    = SDL_ACK;
          end else begin
            overrun_d = 1'b1;
            state_d   = SDL_IDLE;
          end
        end
      end
      SDL_ACK: begin
        if (bit_end) begin
          ack_oe_d = 1'b0;
          state_d  = SDL_IDLE;
        end
      end
      default: state_d = SDL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SDL_IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      ack_oe_q    <= 1'b0;
`ifdef SDL_RX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      ack_oe_q    <= ack_oe_d;
`ifdef SDL_RX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  // Open-drain drive straight from a flop so the enable never glitches.
  assign sdl       = ack_oe_q ? 1'b0 : 1'bz;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != SDL_IDLE);

endmodule

// File: tb/tb_sdl_rx.sv
// Directed bench for sdl_rx: pulled-up line, bufif0 transmitter model, hand-computed expectations.
// Build with SDL_RX_PARITY_EN defined to exercise the parity frames as well.
module tb_sdl_rx;

  localparam int CLK_DIV = 16;
  localparam int DATA_W  = 8;
`ifdef SDL_RX_PARITY_EN
  localparam int STOP_OFS = 171;
`else
  localparam int STOP_OFS = 155;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_ready = 1'b0;
  logic              tx_line = 1'b1;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid, frame_err, overrun, busy;
  tri1               sdl;

  bufif0 u_tx (sdl, 1'b0, tx_line);

  sdl_rx #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sdl       (sdl),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   errors = 0;
  int   checks = 0;
  int   ack_cycles, err_cycles, ovr_cycles, valid_rise, ack_first;
  logic valid_prev = 1'b0;
  int   s;

  // Receiver-driven low cycles are those where the line is low but our transmitter is released.
  always @(negedge clk) begin
    if (sdl == 1'b0 && tx_line) begin
      ack_cycles++;
      if (ack_first < 0) ack_first = cyc;
    end
    if (frame_err) err_cycles++;
    if (overrun) ovr_cycles++;
    if (rx_valid && !valid_prev && valid_rise < 0) valid_rise = cyc;
    valid_prev = rx_valid;
  end

  task automatic clearMonitor();
    ack_cycles = 0;
    err_cycles = 0;
    ovr_cycles = 0;
    valid_rise = -1;
    ack_first  = -1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sends one frame; returns the cycle number at which the start bit was driven.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input logic bad_par, output int start_cyc);
    @(posedge clk); #1;
    start_cyc = cyc;
    tx_line   = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      repeat (CLK_DIV) @(posedge clk);
      #1 tx_line = data[i];
    end
`ifdef SDL_RX_PARITY_EN
    repeat (CLK_DIV) @(posedge clk);
    #1 tx_line = (^data) ^ bad_par;
`else
    if (bad_par) $display("[TB] parity request ignored in this build");
`endif
    repeat (CLK_DIV) @(posedge clk);
    #1 tx_line = stop_bit;
    repeat (CLK_DIV) @(posedge clk);
    #1 tx_line = 1'b1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearMonitor();

    $display("[TB] reset");
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("rst_rx_data", 32'(rx_data), 32'd0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_sdl", 32'(sdl), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    settle(5);

    $display("[TB] frame 0xA5");
    clearMonitor();
    applyStimulus(8'hA5, 1'b1, 1'b0, s);
    settle(20);
    checkOutput("a5_rx_data", 32'(rx_data), 32'hA5);
    checkOutput("a5_rx_valid", 32'(rx_valid), 32'd1);
    checkOutput("a5_valid_latency", 32'(valid_rise - s), 32'(STOP_OFS));
    checkOutput("a5_ack_start", 32'(ack_first - s), 32'(STOP_OFS));
    checkOutput("a5_ack_len", 32'(ack_cycles), 32'd16);
    checkOutput("a5_sdl_released", 32'(sdl), 32'd1);
    checkOutput("a5_frame_err", 32'(err_cycles), 32'd0);
    checkOutput("a5_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rx_ready = 1'b1;
    @(negedge clk);
    checkOutput("a5_hs_cycle_valid", 32'(rx_valid), 32'd1);
    @(posedge clk); #1 rx_ready = 1'b0;
    @(negedge clk);
    checkOutput("a5_after_hs_valid", 32'(rx_valid), 32'd0);

    $display("[TB] 4-cycle glitch");
    clearMonitor();
    @(posedge clk); #1 tx_line = 1'b0;
    repeat (4) @(posedge clk);
    #1 tx_line = 1'b1;
    settle(6);
    checkOutput("glitch_busy_start", 32'(busy), 32'd1);
    settle(10);
    checkOutput("glitch_busy_end", 32'(busy), 32'd0);
    checkOutput("glitch_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("glitch_frame_err", 32'(err_cycles), 32'd0);
    checkOutput("glitch_ack", 32'(ack_cycles), 32'd0);

    $display("[TB] frame 0x3C with bad stop bit");
    clearMonitor();
    applyStimulus(8'h3C, 1'b0, 1'b0, s);
    settle(20);
    checkOutput("badstop_err_pulse", 32'(err_cycles), 32'd1);
    checkOutput("badstop_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("badstop_rx_data", 32'(rx_data), 32'hA5);
    checkOutput("badstop_ack", 32'(ack_cycles), 32'd0);
    checkOutput("badstop_overrun", 32'(ovr_cycles), 32'd0);

    $display("[TB] overrun 0x11 then 0x22");
    clearMonitor();
    rx_ready = 1'b0;
    applyStimulus(8'h11, 1'b1, 1'b0, s);
    settle(20);
    checkOutput("ovr_first_data", 32'(rx_data), 32'h11);
    checkOutput("ovr_first_valid", 32'(rx_valid), 32'd1);
    applyStimulus(8'h22, 1'b1, 1'b0, s);
    settle(20);
    checkOutput("ovr_pulse", 32'(ovr_cycles), 32'd1);
    checkOutput("ovr_frame_err", 32'(err_cycles), 32'd0);
    checkOutput("ovr_data_kept", 32'(rx_data), 32'h11);
    checkOutput("ovr_single_ack", 32'(ack_cycles), 32'd16);
    checkOutput("ovr_valid_held", 32'(rx_valid), 32'd1);
    @(posedge clk); #1 rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
    @(negedge clk);
    checkOutput("ovr_drained", 32'(rx_valid), 32'd0);

`ifdef SDL_RX_PARITY_EN
    $display("[TB] frame 0x0F with bad parity");
    clearMonitor();
    applyStimulus(8'h0F, 1'b1, 1'b1, s);
    settle(20);
    checkOutput("par_err_pulse", 32'(err_cycles), 32'd1);
    checkOutput("par_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("par_ack", 32'(ack_cycles), 32'd0);
`endif

    $display("[TB] reset during DATA, then 0x5A");
    clearMonitor();
    @(posedge clk); #1 tx_line = 1'b0;
    settle(40);
    checkOutput("midrst_busy_before", 32'(busy), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 tx_line = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy_after", 32'(busy), 32'd0);
    checkOutput("midrst_sdl", 32'(sdl), 32'd1);
    checkOutput("midrst_rx_valid", 32'(rx_valid), 32'd0);
    settle(10);
    clearMonitor();
    applyStimulus(8'h5A, 1'b1, 1'b0, s);
    settle(20);
    checkOutput("post_rst_data", 32'(rx_data), 32'h5A);
    checkOutput("post_rst_valid", 32'(rx_valid), 32'd1);
    checkOutput("post_rst_latency", 32'(valid_rise - s), 32'(STOP_OFS));
    checkOutput("post_rst_ack_len", 32'(ack_cycles), 32'd16);
    checkOutput("post_rst_frame_err", 32'(err_cycles), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
